transmitter: RTL

Serial 8b/10b transmit path: accepts bytes or control characters over a valid/ready handshake, encodes them to 10-bit symbols with running-disparity tracking, and shifts them out one bit per clock, bit `a` first. It is the transmit counterpart of the deserializer/decoder receive path. It runs on the single serial-rate clock and derives the word boundary internally with a divide-by-10 counter. When no data is offered, it transmits K28.5 idle commas.

---
 rtl/transmitter_pkg.sv | 30 +++
 rtl/transmitter_if.sv | 12 +
 rtl/transmitter_encoder.sv | 34 +++
 rtl/transmitter.sv | 79 +++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// tx8b10b_pkg: symbol width, running-disparity codes, encode tables and legal-K lookup
package tx8b10b_pkg;
    localparam int WORD_BITS = 10;
    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;
    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    // K28.5 symbols stored with bit 0 = a
    localparam logic [WORD_BITS-1:0] K28_5_NEG = 10'h17C;
    localparam logic [WORD_BITS-1:0] K28_5_POS = 10'h283;
    // RD- codes written abcdei / fghj (a, f as MSB); RD+ forms are complements
    localparam logic [5:0] ENC6_RDN [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [5:0] K28_6B = 6'b001111;
    localparam logic [3:0] ENC4_D_RDN [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    localparam logic [3:0] ENC4_K_RDN [8] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
    };
    localparam logic [3:0] ENC4_A7 = 4'b0111;

    function automatic logic legal_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b[7:5] == 3'd7 &&
               (b[4:0] == 5'd23 || b[4:0] == 5'd27 || b[4:0] == 5'd29 || b[4:0] == 5'd30));
    endfunction
endpackage

// File: rtl/transmitter_if.sv
// transmitter_if: parallel word handshake in, serial line and status out
interface transmitter_if;
    logic [7:0] pdata;
    logic       kin;
    logic       pvalid;
    logic       pready;
    logic       sdata;
    logic       rdispout;
    logic       code_err;
    modport master (output pdata, kin, pvalid, input pready, sdata, rdispout, code_err);
    modport slave (input pdata, kin, pvalid, output pready, sdata, rdispout, code_err);
endinterface

// File: rtl/transmitter_encoder.sv
// encoder: combinational 8b/10b encoder; illegal control codes become K28.5 with code_err
module encoder
    import tx8b10b_pkg::*;
(
    input  logic [7:0]           datin,
    input  logic                 kin,
    input  logic                 rdispin,
    output logic [WORD_BITS-1:0] datout,
    output logic                 rdispout,
    output logic                 code_err
);
    logic [5:0] b6, c6;
    logic [3:0] b4, c4;
    logic       rd4, alt, rd_sym;
    logic [WORD_BITS-1:0] sym, rev;

    // 5b/6b then 3b/4b, each block picking its RD+ form by complementing the RD- code
    always_comb begin
        code_err = kin && !legal_k(datin);
        b6 = (kin && datin[4:0] == 5'd28) ? K28_6B : ENC6_RDN[datin[4:0]];
        c6 = (rdispin && ($countones(b6) != 3 || datin[4:0] == 5'd7)) ? ~b6 : b6;
        rd4 = ($countones(b6) != 3) ? ~rdispin : rdispin;
        alt = rd4 ? (datin[4:0] == 5'd11 || datin[4:0] == 5'd13 || datin[4:0] == 5'd14)
                  : (datin[4:0] == 5'd17 || datin[4:0] == 5'd18 || datin[4:0] == 5'd20);
        b4 = kin ? ENC4_K_RDN[datin[7:5]] : (datin[7:5] == 3'd7 && alt) ? ENC4_A7 : ENC4_D_RDN[datin[7:5]];
        c4 = (rd4 && (kin || $countones(b4) != 2 || datin[7:5] == 3'd3)) ? ~b4 : b4;
        rd_sym = ($countones(b4) != 2) ? ~rd4 : rd4;
        sym = {c6, c4};
        rev = '0;
        for (int i = 0; i < WORD_BITS; i++) rev[i] = sym[WORD_BITS-1-i];
        datout = code_err ? (rdispin == RD_POS ? K28_5_POS : K28_5_NEG) : rev;
        rdispout = code_err ? ~rdispin : rd_sym;
    end
endmodule

// File: rtl/transmitter.sv
// transmitter: 8b/10b serial transmit path, one bit per clock, bit a first.
// Defining TX_PREAMBLE_EN sends PREAMBLE_WORDS K28.5 words after reset before accepting data.
module transmitter
    import tx8b10b_pkg::*;
#(
    parameter int PREAMBLE_WORDS = 4
) (
    input logic          clk,
    input logic          reset,
    transmitter_if.slave bus
);
    logic [3:0]           bcnt_q, bcnt_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d, enc_dout;
    logic                 sdata_q, sdata_d, rd_q, rd_d, err_q, err_d;
    logic                 load, take, enc_kin, enc_rd, enc_err;
    logic [7:0]           enc_din;

    assign load = bcnt_q == 4'(WORD_BITS - 1);
`ifdef TX_PREAMBLE_EN
    logic [7:0] pre_q, pre_d;

    assign bus.pready = load && pre_q == 8'd0;

    // preamble countdown, one step per load edge while still active
    always_comb begin
        pre_d = (load && pre_q != 8'd0) ? pre_q - 8'd1 : pre_q;
    end

    // preamble counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_q <= 8'(PREAMBLE_WORDS);
        else pre_q <= pre_d;
    end
`else
    assign bus.pready = load;
`endif
    assign take = bus.pvalid && bus.pready;
    assign enc_din = take ? bus.pdata : K28_5_BYTE;
    assign enc_kin = take ? bus.kin : 1'b1;

    encoder u_enc (
        .datin(enc_din),
        .kin(enc_kin),
        .rdispin(rd_q),
        .datout(enc_dout),
        .rdispout(enc_rd),
        .code_err(enc_err)
    );

    // word-boundary counter, shift/load of the symbol, RD and error update at load edges
    always_comb begin
        bcnt_d = load ? 4'd0 : bcnt_q + 4'd1;
        shreg_d = load ? enc_dout : {1'b0, shreg_q[WORD_BITS-1:1]};
        sdata_d = shreg_q[0];
        rd_d = load ? enc_rd : rd_q;
        err_d = load ? enc_err : err_q;
    end

    // state registers; reset aborts any symbol in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            shreg_q <= '0;
            sdata_q <= 1'b0;
            rd_q <= RD_NEG;
            err_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            shreg_q <= shreg_d;
            sdata_q <= sdata_d;
            rd_q <= rd_d;
            err_q <= err_d;
        end
    end

    assign bus.sdata = sdata_q;
    assign bus.rdispout = rd_q;
    assign bus.code_err = err_q;
endmodule
